// File: rtl/coin_input_conditioner_pkg.sv
// coin_pkg: shared coin encodings, values and the per-slot debounce state type.
package coin_pkg;
  localparam int VALUE_W = 7;
  localparam logic [VALUE_W-1:0] VAL_N = 7'd5;
  localparam logic [VALUE_W-1:0] VAL_I = 7'd10;
  localparam logic [VALUE_W-1:0] VAL_Q = 7'd25;
  localparam logic [VALUE_W-1:0] VAL_D = 7'd100;
  typedef enum logic [1:0] {COIN_N, COIN_I, COIN_Q, COIN_D} coin_e;
  typedef enum logic [2:0] {WAIT_LOW, IDLE, ARMING, HELD, RELEASING} slot_e;
  function automatic logic [VALUE_W-1:0] coin_val(coin_e c);
    return c == COIN_N ? VAL_N : c == COIN_I ? VAL_I : c == COIN_Q ? VAL_Q : VAL_D;
  endfunction
endpackage

// File: rtl/coin_input_conditioner_if.sv
// coin_input_conditioner_if: raw slot switches, accept_en and conditioned coin outputs.
//   slave  = conditioner side (raw_*, accept_en in; N/I/Q/D, coin_value, coin_reject out)
//   master = driver/observer side
//   COIN_TALLY_EN adds tally_clr and tally_n/i/q/d.
interface coin_input_conditioner_if;
  import coin_pkg::*;
  logic raw_n, raw_i, raw_q, raw_d, accept_en;
  logic N, I, Q, D, coin_reject;
  logic [VALUE_W-1:0] coin_value;
`ifdef COIN_TALLY_EN
  logic tally_clr;
  logic [7:0] tally_n, tally_i, tally_q, tally_d;
  modport slave (input raw_n, raw_i, raw_q, raw_d, accept_en, tally_clr,
                 output N, I, Q, D, coin_value, coin_reject, tally_n, tally_i, tally_q, tally_d);
  modport master (output raw_n, raw_i, raw_q, raw_d, accept_en, tally_clr,
                  input N, I, Q, D, coin_value, coin_reject, tally_n, tally_i, tally_q, tally_d);
`else
  modport slave (input raw_n, raw_i, raw_q, raw_d, accept_en,
                 output N, I, Q, D, coin_value, coin_reject);
  modport master (output raw_n, raw_i, raw_q, raw_d, accept_en,
                  input N, I, Q, D, coin_value, coin_reject);
`endif
endinterface

// File: rtl/coin_input_conditioner_debounce.sv
// coin_debounce: two-flop synchroniser plus debounce FSM for one coin slot.
//   clk, rst (async, active high), raw (asynchronous switch) -> event_o (one-cycle request per insertion)
module coin_debounce
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic event_o
);
  logic sync1_q, sync2_q, event_q, event_d, done;
  slot_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  // Synchroniser resets high so a switch held through reset reads as pressed
  // until real samples arrive; WAIT_LOW then insists on a genuine low run.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= WAIT_LOW;
      cnt_q   <= '0;
      event_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      event_q <= event_d;
    end
  assign cnt_inc = cnt_q + 1'b1;
  assign done = cnt_inc == CNT_W'(DEBOUNCE_CYCLES);
  // cnt_q is always 0 in IDLE and HELD, so those share the counting arms.
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    event_d = 1'b0;
    case (state_q)
      WAIT_LOW: begin
        state_d = (!sync2_q && done) ? IDLE : WAIT_LOW;
        cnt_d = (sync2_q || done) ? '0 : cnt_inc;
      end
      IDLE, ARMING: begin
        state_d = !sync2_q ? IDLE : done ? HELD : ARMING;
        cnt_d = (!sync2_q || done) ? '0 : cnt_inc;
        event_d = sync2_q && done;
      end
      HELD, RELEASING: begin
        state_d = sync2_q ? HELD : done ? IDLE : RELEASING;
        cnt_d = (sync2_q || done) ? '0 : cnt_inc;
      end
      default: state_d = WAIT_LOW;
    endcase
  end
  assign event_o = event_q;
endmodule

// File: rtl/coin_input_conditioner.sv
// coin_input_conditioner: debounces four coin slots and arbitrates them into clean coin pulses.
//   clk, rst (async, active high), bus (coin_input_conditioner_if.slave)
//   Optional COIN_TALLY_EN: saturating per-denomination tallies with synchronous clear.
module coin_input_conditioner
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W = 3
) (
  input logic clk,
  input logic rst,
  coin_input_conditioner_if.slave bus
);
  logic [3:0] raw, req, coin_d, coin_q;
  logic take, reject_d, reject_q;
  logic [VALUE_W-1:0] value_d, value_q;
  assign raw = {bus.raw_d, bus.raw_q, bus.raw_i, bus.raw_n};
  for (genvar g = 0; g < 4; g++) begin : g_slot
    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb (
      .clk(clk), .rst(rst), .raw(raw[g]), .event_o(req[g])
    );
  end
  // A lone request is accepted only while the FSM collects; anything else is returned.
  always_comb begin
    take = (req != 4'd0) && ((req & (req - 4'd1)) == 4'd0) && bus.accept_en;
    coin_d = take ? req : 4'd0;
    reject_d = (req != 4'd0) && !take;
    value_d = coin_d[0] ? coin_val(COIN_N) : coin_d[1] ? coin_val(COIN_I) :
              coin_d[2] ? coin_val(COIN_Q) : coin_d[3] ? coin_val(COIN_D) : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      coin_q <= '0;
      value_q <= '0;
      reject_q <= 1'b0;
    end else begin
      coin_q <= coin_d;
      value_q <= value_d;
      reject_q <= reject_d;
    end
  assign {bus.D, bus.Q, bus.I, bus.N} = coin_q;
  assign bus.coin_value = value_q;
  assign bus.coin_reject = reject_q;
`ifdef COIN_TALLY_EN
  logic [3:0][7:0] tally_q, tally_d;
  always_comb begin
    tally_d = tally_q;
    for (int k = 0; k < 4; k++)
      tally_d[k] = bus.tally_clr ? 8'd0 :
                   (coin_d[k] && tally_q[k] != 8'hFF) ? tally_q[k] + 8'd1 : tally_q[k];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) tally_q <= '0;
    else tally_q <= tally_d;
  assign bus.tally_n = tally_q[0];
  assign bus.tally_i = tally_q[1];
  assign bus.tally_q = tally_q[2];
  assign bus.tally_d = tally_q[3];
`endif
endmodule

// File: tb/tb_coin_input_conditioner.sv
// tb_coin_input_conditioner: directed and randomized stimulus against a run-length coin model.
module tb_coin_input_conditioner;
  localparam int DB = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  coin_input_conditioner_if bus();
  coin_input_conditioner #(.DEBOUNCE_CYCLES(DB), .CNT_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  int vectors = 0;
  int miscompares = 0;
  int lo_run[4], hi_run[4], tally[4];
  bit armed[4], p1[4], p2[4];
  logic [3:0] req_prev;
  int vals[4] = '{5, 10, 25, 100};
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      lo_run[k] = 0;
      hi_run[k] = 0;
      armed[k] = 0;
      p1[k] = 1;
      p2[k] = 1;
      tally[k] = 0;
    end
    req_prev = 4'd0;
  endtask
  // Reference: a slot becomes armed after DB consecutive low samples; an armed
  // slot requests when its high run reaches DB, then disarms. Samples reach the
  // debouncer two edges late; pre-reset history counts as high.
  task automatic cycle();
    logic [3:0] raw_now, nreq, exp_coin;
    logic exp_rej, take, clr;
    int n, exp_val;
    @(posedge clk);
    #1;
    raw_now = {bus.raw_d, bus.raw_q, bus.raw_i, bus.raw_n};
`ifdef COIN_TALLY_EN
    clr = bus.tally_clr;
`else
    clr = 1'b0;
`endif
    exp_coin = 4'd0;
    exp_rej = 1'b0;
    exp_val = 0;
    if (rst) model_reset();
    else begin
      n = $countones(req_prev);
      take = (n == 1) && bus.accept_en;
      exp_coin = take ? req_prev : 4'd0;
      exp_rej = (n != 0) && !take;
      nreq = 4'd0;
      for (int k = 0; k < 4; k++) begin
        if (exp_coin[k]) exp_val = vals[k];
        if (clr) tally[k] = 0;
        else if (exp_coin[k] && tally[k] < 255) tally[k]++;
        if (p2[k]) begin
          hi_run[k]++;
          lo_run[k] = 0;
          if (armed[k] && hi_run[k] == DB) begin
            nreq[k] = 1'b1;
            armed[k] = 0;
          end
        end else begin
          lo_run[k]++;
          hi_run[k] = 0;
          if (lo_run[k] >= DB) armed[k] = 1;
        end
        p2[k] = p1[k];
        p1[k] = raw_now[k];
      end
      req_prev = nreq;
    end
    check("pulses_DQIN", {28'd0, bus.D, bus.Q, bus.I, bus.N}, {28'd0, exp_coin});
    check("coin_value", {25'd0, bus.coin_value}, exp_val);
    check("coin_reject", {31'd0, bus.coin_reject}, {31'd0, exp_rej});
`ifdef COIN_TALLY_EN
    check("tally_n", {24'd0, bus.tally_n}, tally[0]);
    check("tally_i", {24'd0, bus.tally_i}, tally[1]);
    check("tally_q", {24'd0, bus.tally_q}, tally[2]);
    check("tally_d", {24'd0, bus.tally_d}, tally[3]);
`endif
  endtask
  task automatic run(logic [3:0] r, logic a, int n);
    {bus.raw_d, bus.raw_q, bus.raw_i, bus.raw_n} = r;
    bus.accept_en = a;
    repeat (n) cycle();
  endtask
  initial begin
    int left[4];
    logic [3:0] r;
    model_reset();
    {bus.raw_d, bus.raw_q, bus.raw_i, bus.raw_n} = 4'b0001;
    bus.accept_en = 1'b1;
`ifdef COIN_TALLY_EN
    bus.tally_clr = 1'b0;
`endif
    run(4'b0001, 1, 3);
    rst = 1'b0;
    run(4'b0001, 1, 10);
    run(4'b0000, 1, 6);
    run(4'b0001, 1, 8);
    run(4'b0000, 1, 6);
    run(4'b0100, 1, 20);
    run(4'b0000, 1, 6);
    run(4'b0001, 1, 3);
    run(4'b0000, 1, 8);
    run(4'b1010, 1, 10);
    run(4'b0000, 1, 6);
    run(4'b1000, 0, 10);
    run(4'b0000, 1, 6);
    run(4'b0100, 1, 3);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    run(4'b0100, 1, 10);
    run(4'b0000, 1, 6);
    r = 4'b0000;
    for (int k = 0; k < 4; k++) left[k] = $urandom_range(1, 8);
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (left[k] == 0) begin
          r[k] = ~r[k];
          left[k] = r[k] ? $urandom_range(1, 9) : $urandom_range(1, 8);
        end
        left[k]--;
      end
      {bus.raw_d, bus.raw_q, bus.raw_i, bus.raw_n} = r;
      if ($urandom_range(0, 9) == 0) bus.accept_en = $urandom_range(0, 3) != 0;
      rst = $urandom_range(0, 699) == 0;
`ifdef COIN_TALLY_EN
      bus.tally_clr = $urandom_range(0, 199) == 0;
`endif
      cycle();
    end
    rst = 1'b0;
`ifdef COIN_TALLY_EN
    bus.tally_clr = 1'b0;
`endif
    run(4'b0000, 1, 8);
`ifdef COIN_TALLY_EN
    repeat (300) begin
      run(4'b0001, 1, 5);
      run(4'b0000, 1, 5);
    end
    bus.tally_clr = 1'b1;
    run(4'b0001, 1, 5);
    run(4'b0000, 1, 5);
    bus.tally_clr = 1'b0;
    run(4'b0000, 1, 2);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
